pulse_stretch: RTL and testbench
================================

Name: pulse_stretch

Overview:
- Output-side counterpart to the input debouncer. Input debouncing drops short glitches; this block widens short event pulses into fixed-width, visible pulses.
- Each channel turns a rising edge on data_in into an output pulse of exactly HOLD cycles. A guaranteed inactive gap of GAP cycles follows each pulse.
- Sits between fabric event sources (step/limit/status strobes) and board LEDs or slow external indicators.
- One independent channel per bit. Clock and reset are shared.

Parameters:
- WIDTH, 2, number of independent channels.
- POLARITY, "LOW", active level of data_out: "HIGH" or "LOW" (LEDs are active-low).
- HOLD, 5000000, output active time in clk cycles; must be >= 1.
- GAP, 2500000, minimum inactive time after each pulse, in clk cycles; 0 is allowed.
- RETRIGGER, 1, 1 = an event during ON restarts the HOLD count; 0 = the event is queued as pending.
- CNT_WIDTH, 23, counter width; must be >= ceil(log2(max(HOLD, GAP, 2))).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- data_in  in  WIDTH  active-high event inputs, synchronous to clk; rising edge = event.
- data_out  out  WIDTH  stretched pulses; active level set by POLARITY; registered.
- busy  out  WIDTH  per channel, 1 when state != IDLE or pending = 1.

Behaviour:
- Per-channel registers: prev (last data_in), state {IDLE, ON, GAP}, cnt[CNT_WIDTH-1:0], pending.
- All registers use an asynchronous, active-low reset.
- Reset values: prev=0, state=IDLE, cnt=0, pending=0.
  - data_out = inactive level: all 1s for "LOW", all 0s for "HIGH".
  - busy = 0.
- evt = data_in & ~prev, evaluated at each clk edge. prev <= data_in every cycle. A level held high produces exactly one event.
- IDLE:
  - evt -> ON, cnt <= HOLD-1.
  - Output goes active immediately after the edge that sampled the rising data_in (1-cycle latency from data_in change).
- ON (data_out active):
  - cnt != 0: cnt <= cnt-1.
  - cnt == 0 and GAP > 0: -> GAP state, cnt <= GAP-1.
  - cnt == 0 and GAP == 0: pending or evt -> stay ON, cnt <= HOLD-1, pending <= 0 (output stays continuous). Otherwise -> IDLE.
  - evt with RETRIGGER=1: cnt <= HOLD-1. This wins over the cnt == 0 exit.
  - evt with RETRIGGER=0: pending <= 1. The count is unaffected.
  - Without retrigger, output is active for exactly HOLD cycles.
- GAP (data_out inactive):
  - evt: pending <= 1.
  - cnt != 0: cnt <= cnt-1.
  - cnt == 0 and (pending or evt): -> ON, cnt <= HOLD-1, pending <= 0.
  - cnt == 0 otherwise: -> IDLE.
- Pending queue depth is 1. Any number of events while pending=1 collapse into a single extra pulse.
- data_out is driven from a registered state bit: no combinational path from data_in.
- Channels are fully independent. Simultaneous events on several channels are each handled per the rules above.
- Reset asserted mid-pulse: output goes inactive immediately (asynchronous) and pending is dropped.
- After reset release: an input already high gives an event on the first clock, because prev resets to 0.

Test Plan:
- Pulse and gap (WIDTH=2, HOLD=4, GAP=2, POLARITY="HIGH", RETRIGGER=1): 1-cycle pulse on data_in[0] at edge k -> data_out[0]=1 after edges k..k+3, 0 after edge k+4. busy[0]=1 for 6 cycles. data_out[1] and busy[1] stay 0.
- Held input: data_in[0] high for 20 cycles -> exactly one 4-cycle pulse, then busy[0]=0.
- Retrigger: second rising edge 2 cycles after the first -> output active 6 cycles total.
- RETRIGGER=0: same stimulus -> 4 active, 2 inactive, then 4 active; busy[0] low only after that.
- Three events during GAP -> exactly one extra 4-cycle pulse.
- Event at the last GAP cycle -> ON on the next cycle.
- POLARITY="LOW": idle data_out=2'b11 and a pulse drives the bit to 0.
- reset_n dropped mid-ON with pending=1 -> data_out=2'b11 asynchronously, no pulse after release.
- GAP=0, event in the last ON cycle with RETRIGGER=0 -> output continuously active for 8 cycles.

Source files
------------

// File: rtl/pulse_stretch_if.sv
// pulse_stretch_if: bundles the per-channel event inputs and the stretched
// outputs of pulse_stretch.
//   data_in  : active-high event strobes, rising edge = event (master -> slave)
//   data_out : stretched pulses, active level chosen by the stretcher
//   busy     : channel is pulsing, in its gap, or holding a pending event
// The slave modport is the stretcher; the master modport is the event source.
interface pulse_stretch_if #(
    parameter int WIDTH = 2
);
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] busy;

    modport master (output data_in, input data_out, input busy);
    modport slave  (input data_in, output data_out, output busy);
endinterface

// File: rtl/pulse_stretch.sv
// pulse_stretch: widens short event strobes into fixed-width pulses that are
// long enough to see on an LED or a slow external indicator.
// Each bit is an independent channel.
//
// Channel behaviour:
//   - A rising edge on data_in starts a pulse of HOLD cycles.
//   - After the pulse, the output stays inactive for at least GAP cycles.
//   - An event during the pulse either restarts the count (RETRIGGER=1) or is
//     queued as a single pending pulse (RETRIGGER=0).
//   - Events during the gap are always queued.
//   - The pending queue holds one entry.
//
// Ports:
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : slave side of pulse_stretch_if
//             (data_in in, data_out / busy out)
//
// The interface instance must be sized with the same WIDTH as this module.
module pulse_stretch #(
    parameter int WIDTH     = 2,
    parameter     POLARITY  = "LOW",
    parameter int HOLD      = 5000000,
    parameter int GAP       = 2500000,
    parameter int RETRIGGER = 1,
    parameter int CNT_WIDTH = 23
) (
    input  logic             clk,
    input  logic             reset_n,
    pulse_stretch_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic                 ACTIVE_LOW = (POLARITY == "LOW");
    localparam logic [CNT_WIDTH-1:0] HOLD_LOAD  = CNT_WIDTH'(HOLD - 1);
    localparam logic [CNT_WIDTH-1:0] GAP_LOAD   = (GAP > 0) ? CNT_WIDTH'(GAP - 1) : '0;

    logic [WIDTH-1:0] on_vec;
    logic [WIDTH-1:0] busy_vec;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_chan
            state_t               state_reg, state_next;
            logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
            logic                 pending_reg, pending_next;
            logic                 prev_reg;
            logic                 evt;

            // A level held high yields exactly one event.
            // prev resets low, so an input already high at release counts
            // as an event on the first clock.
            assign evt = bus.data_in[gi] & ~prev_reg;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    prev_reg    <= 1'b0;
                    state_reg   <= ST_IDLE;
                    cnt_reg     <= '0;
                    pending_reg <= 1'b0;
                end else begin
                    prev_reg    <= bus.data_in[gi];
                    state_reg   <= state_next;
                    cnt_reg     <= cnt_next;
                    pending_reg <= pending_next;
                end
            end

            always_comb begin
                state_next   = state_reg;
                cnt_next     = cnt_reg;
                pending_next = pending_reg;
                case (state_reg)
                    ST_IDLE: begin
                        if (evt) begin
                            state_next = ST_ON;
                            cnt_next   = HOLD_LOAD;
                        end
                    end
                    ST_ON: begin
                        if ((RETRIGGER != 0) && evt) begin
                            // A retrigger wins over the end-of-pulse exit.
                            cnt_next = HOLD_LOAD;
                        end else if (cnt_reg != '0) begin
                            cnt_next = cnt_reg - CNT_WIDTH'(1);
                            if (evt) pending_next = 1'b1;
                        end else if (GAP > 0) begin
                            state_next = ST_GAP;
                            cnt_next   = GAP_LOAD;
                            if (evt) pending_next = 1'b1;
                        end else if (pending_reg || evt) begin
                            // With no gap, a queued event continues the pulse
                            // seamlessly.
                            cnt_next     = HOLD_LOAD;
                            pending_next = 1'b0;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end
                    ST_GAP: begin
                        if (cnt_reg != '0) begin
                            cnt_next = cnt_reg - CNT_WIDTH'(1);
                            if (evt) pending_next = 1'b1;
                        end else if (pending_reg || evt) begin
                            state_next   = ST_ON;
                            cnt_next     = HOLD_LOAD;
                            pending_next = 1'b0;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end
                    default: begin
                        state_next   = ST_IDLE;
                        cnt_next     = '0;
                        pending_next = 1'b0;
                    end
                endcase
            end

            // The output is a decode of registered state only, so data_in has
            // no combinational path to data_out.
            assign on_vec[gi]   = (state_reg == ST_ON);
            assign busy_vec[gi] = (state_reg != ST_IDLE) | pending_reg;
        end
    endgenerate

    assign bus.data_out = ACTIVE_LOW ? ~on_vec : on_vec;
    assign bus.busy     = busy_vec;

endmodule

// File: tb/tb_pulse_stretch.sv
// Testbench for pulse_stretch.
// Four instances cover the parameter corners:
//   dut 0: HOLD=4, GAP=2, HIGH, RETRIGGER=1
//   dut 1: HOLD=4, GAP=2, HIGH, RETRIGGER=0
//   dut 2: HOLD=4, GAP=2, LOW,  RETRIGGER=0
//   dut 3: HOLD=4, GAP=0, HIGH, RETRIGGER=0
// Each vector drives one instance's data_in before a clock edge. The other
// instances get zero. The selected instance's outputs are then compared 1 time
// unit after that edge.
module tb_pulse_stretch;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    pulse_stretch_if #(.WIDTH(2)) if_a ();
    pulse_stretch_if #(.WIDTH(2)) if_b ();
    pulse_stretch_if #(.WIDTH(2)) if_c ();
    pulse_stretch_if #(.WIDTH(2)) if_d ();

    pulse_stretch #(.WIDTH(2), .POLARITY("HIGH"), .HOLD(4), .GAP(2), .RETRIGGER(1), .CNT_WIDTH(4))
        dut_a (.clk(clk), .reset_n(reset_n), .bus(if_a.slave));
    pulse_stretch #(.WIDTH(2), .POLARITY("HIGH"), .HOLD(4), .GAP(2), .RETRIGGER(0), .CNT_WIDTH(4))
        dut_b (.clk(clk), .reset_n(reset_n), .bus(if_b.slave));
    pulse_stretch #(.WIDTH(2), .POLARITY("LOW"), .HOLD(4), .GAP(2), .RETRIGGER(0), .CNT_WIDTH(4))
        dut_c (.clk(clk), .reset_n(reset_n), .bus(if_c.slave));
    pulse_stretch #(.WIDTH(2), .POLARITY("HIGH"), .HOLD(4), .GAP(0), .RETRIGGER(0), .CNT_WIDTH(4))
        dut_d (.clk(clk), .reset_n(reset_n), .bus(if_d.slave));

    typedef struct {
        string      tag;
        int         dut;
        logic [1:0] din;
        logic [1:0] out;
        logic [1:0] busy;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input string tag, input int dut, input logic [1:0] din,
                       input logic [1:0] out, input logic [1:0] busy, input int reps = 1);
        vec_t v;
        v.tag  = tag;
        v.dut  = dut;
        v.din  = din;
        v.out  = out;
        v.busy = busy;
        for (int r = 0; r < reps; r++) vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic get(input int d, output logic [1:0] o, output logic [1:0] b);
        case (d)
            0:       begin o = if_a.data_out; b = if_a.busy; end
            1:       begin o = if_b.data_out; b = if_b.busy; end
            2:       begin o = if_c.data_out; b = if_c.busy; end
            default: begin o = if_d.data_out; b = if_d.busy; end
        endcase
    endtask

    // Drive one instance's data_in before the next rising edge. The others
    // are driven to zero. Return 1 time unit after that edge.
    task automatic apply(input int d, input logic [1:0] din);
        @(negedge clk);
        if_a.data_in = (d == 0) ? din : 2'b00;
        if_b.data_in = (d == 1) ? din : 2'b00;
        if_c.data_in = (d == 2) ? din : 2'b00;
        if_d.data_in = (d == 3) ? din : 2'b00;
        @(posedge clk);
        #1;
    endtask

    task automatic step_check(input string tag, input int d, input logic [1:0] din,
                              input logic [1:0] eo, input logic [1:0] eb);
        logic [1:0] o, b;
        apply(d, din);
        get(d, o, b);
        $display("t=%0t %s dut%0d din=%b out=%b busy=%b", $time, tag, d, din, o, b);
        check({tag, " out"}, o, eo);
        check({tag, " busy"}, b, eb);
    endtask

    initial begin
        logic [1:0] o, b;

        // Single-cycle pulse: 4 active cycles, then 2 gap cycles with busy still high.
        add("pulse", 0, 2'b01, 2'b01, 2'b01);
        add("pulse", 0, 2'b00, 2'b01, 2'b01, 3);
        add("pulse", 0, 2'b00, 2'b00, 2'b01, 2);
        add("pulse", 0, 2'b00, 2'b00, 2'b00);

        // Simultaneous events on both channels.
        add("both", 0, 2'b11, 2'b11, 2'b11);
        add("both", 0, 2'b00, 2'b11, 2'b11, 3);
        add("both", 0, 2'b00, 2'b00, 2'b11, 2);
        add("both", 0, 2'b00, 2'b00, 2'b00);

        // Retrigger 2 cycles after the first edge: 6 active cycles.
        add("retrig", 0, 2'b01, 2'b01, 2'b01);
        add("retrig", 0, 2'b00, 2'b01, 2'b01);
        add("retrig", 0, 2'b01, 2'b01, 2'b01);
        add("retrig", 0, 2'b00, 2'b01, 2'b01, 3);
        add("retrig", 0, 2'b00, 2'b00, 2'b01, 2);
        add("retrig", 0, 2'b00, 2'b00, 2'b00);

        // Same stimulus without retrigger: 4 on, 2 off, 4 on, 2 off.
        add("queue", 1, 2'b01, 2'b01, 2'b01);
        add("queue", 1, 2'b00, 2'b01, 2'b01);
        add("queue", 1, 2'b01, 2'b01, 2'b01);
        add("queue", 1, 2'b00, 2'b01, 2'b01);
        add("queue", 1, 2'b00, 2'b00, 2'b01, 2);
        add("queue", 1, 2'b00, 2'b01, 2'b01, 4);
        add("queue", 1, 2'b00, 2'b00, 2'b01, 2);
        add("queue", 1, 2'b00, 2'b00, 2'b00);

        // Three events while pending collapse into one extra pulse.
        add("collapse", 1, 2'b01, 2'b01, 2'b01);
        add("collapse", 1, 2'b00, 2'b01, 2'b01);
        add("collapse", 1, 2'b01, 2'b01, 2'b01);
        add("collapse", 1, 2'b00, 2'b01, 2'b01);
        add("collapse", 1, 2'b01, 2'b00, 2'b01);
        add("collapse", 1, 2'b00, 2'b00, 2'b01);
        add("collapse", 1, 2'b01, 2'b01, 2'b01);
        add("collapse", 1, 2'b00, 2'b01, 2'b01, 3);
        add("collapse", 1, 2'b00, 2'b00, 2'b01, 2);
        add("collapse", 1, 2'b00, 2'b00, 2'b00);

        // Event sampled in the last gap cycle: ON on the very next cycle.
        add("lastgap", 0, 2'b01, 2'b01, 2'b01);
        add("lastgap", 0, 2'b00, 2'b01, 2'b01, 3);
        add("lastgap", 0, 2'b00, 2'b00, 2'b01, 2);
        add("lastgap", 0, 2'b01, 2'b01, 2'b01);
        add("lastgap", 0, 2'b00, 2'b01, 2'b01, 3);
        add("lastgap", 0, 2'b00, 2'b00, 2'b01, 2);
        add("lastgap", 0, 2'b00, 2'b00, 2'b00);

        // Active-low outputs: idle is 11, and a pulse on channel 1 drives bit 1 low.
        add("lowpol", 2, 2'b00, 2'b11, 2'b00);
        add("lowpol", 2, 2'b10, 2'b01, 2'b10);
        add("lowpol", 2, 2'b00, 2'b01, 2'b10, 3);
        add("lowpol", 2, 2'b00, 2'b11, 2'b10, 2);
        add("lowpol", 2, 2'b00, 2'b11, 2'b00);

        // No gap, event in the last ON cycle: 8 continuous active cycles.
        add("gap0", 3, 2'b01, 2'b01, 2'b01);
        add("gap0", 3, 2'b00, 2'b01, 2'b01, 3);
        add("gap0", 3, 2'b01, 2'b01, 2'b01);
        add("gap0", 3, 2'b00, 2'b01, 2'b01, 3);
        add("gap0", 3, 2'b00, 2'b00, 2'b00);

        if_a.data_in = 2'b00;
        if_b.data_in = 2'b00;
        if_c.data_in = 2'b00;
        if_d.data_in = 2'b00;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("reset a out", if_a.data_out, 2'b00);
        check("reset a busy", if_a.busy, 2'b00);
        check("reset c out", if_c.data_out, 2'b11);
        check("reset c busy", if_c.busy, 2'b00);
        check("reset d out", if_d.data_out, 2'b00);
        @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[i]) step_check(vecs[i].tag, vecs[i].dut, vecs[i].din, vecs[i].out, vecs[i].busy);

        // Input held high for 20 cycles gives exactly one pulse.
        for (int i = 0; i < 20; i++)
            step_check("held", 0, 2'b01, (i < 4) ? 2'b01 : 2'b00, (i < 6) ? 2'b01 : 2'b00);
        step_check("held", 0, 2'b00, 2'b00, 2'b00);

        // Reset mid-ON with pending=1 on the active-low instance.
        step_check("rstmid", 2, 2'b01, 2'b10, 2'b01);
        step_check("rstmid", 2, 2'b00, 2'b10, 2'b01);
        step_check("rstmid", 2, 2'b01, 2'b10, 2'b01);
        #2;
        if_a.data_in = 2'b01;  // high through reset release
        reset_n = 1'b0;
        #1;
        get(2, o, b);
        $display("t=%0t rstmid async out=%b busy=%b", $time, o, b);
        check("rstmid async out", o, 2'b11);
        check("rstmid async busy", b, 2'b00);
        @(negedge clk);
        reset_n = 1'b1;
        if_c.data_in = 2'b00;
        @(posedge clk);
        #1;
        $display("t=%0t rstrel a out=%b busy=%b", $time, if_a.data_out, if_a.busy);
        check("rstrel high input out", if_a.data_out, 2'b01);
        check("rstrel high input busy", if_a.busy, 2'b01);
        // The dropped pending event must not produce a pulse.
        for (int i = 0; i < 8; i++) step_check("postrst", 2, 2'b00, 2'b11, 2'b00);
        check("postrst a busy", if_a.busy, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
